// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

    // Defaults shared with the transmitter so both ends agree on line timing.
    localparam int DEFAULT_CLK_FREQ  = 100_000;
    localparam int DEFAULT_BAUD_RATE = 9600;
    localparam int DATA_BITS         = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx pin synchroniser with falling-edge detect
module uart_rx_sync (
    input  logic clk,        // system clock
    input  logic rst,        // asynchronous active-high reset
    input  logic rx,         // raw serial line, asynchronous to clk
    output logic rx_s,       // synchronised line
    output logic fall_edge   // rx_s went 1 -> 0 this cycle
);

    logic       rx_meta;
    logic       rx_s_d;
    logic [2:0] primed;

    // All line flops reset to 1 so the idle level is assumed through reset.
    // primed marks when rx_s_d holds a genuine post-reset sample; without it
    // a line held low across reset would look like a 1->0 edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
            primed  <= 3'b000;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
            primed  <= {primed[1:0], 1'b1};
        end
    end

    assign fall_edge = primed[2] & rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with a one-byte valid/ready output
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int BIT_TICKS  = CLK_FREQ / BAUD_RATE,
    parameter int HALF_TICKS = BIT_TICKS / 2
) (
    input  logic                 clk,        // system clock
    input  logic                 rst,        // asynchronous active-high reset
    input  logic                 rx,         // serial line, idle high
    output logic [DATA_BITS-1:0] rx_data,    // last good byte
    output logic                 rx_valid,   // byte pending until accepted
    input  logic                 rx_ready,   // consumer accepts on valid&&ready
    output logic                 frame_err,  // pulse: stop bit sampled 0
    output logic                 overrun,    // pulse: pending byte overwritten
    output logic                 busy        // receiver not idle
);

    localparam int CNT_W = $clog2(BIT_TICKS);
    localparam int IDX_W = $clog2(DATA_BITS);

    generate
        if (BIT_TICKS < 4) begin : g_bit_ticks_check
            $error("uart_receiver: BIT_TICKS must be at least 4");
        end
    endgenerate

    logic                 rx_s;
    logic                 fall_edge;
    rx_state_t            state;
    rx_state_t            next_state;
    logic [CNT_W-1:0]     tick_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 bit_end;
    logic                 half_end;
    logic                 bit_sample;
    logic                 stop_sample;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_s      (rx_s),
        .fall_edge (fall_edge)
    );

    assign bit_end  = (tick_cnt == CNT_W'(BIT_TICKS - 1));
    assign half_end = (tick_cnt == CNT_W'(HALF_TICKS - 1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        bit_sample  = 1'b0;
        stop_sample = 1'b0;
        case (state)
            IDLE: begin
                if (fall_edge) begin
                    next_state = START;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (half_end) begin
                    next_state = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_sample = 1'b1;
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    stop_sample = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Restart the bit timer on every state change and at each bit
            // boundary, so it never runs past BIT_TICKS-1.
            if ((next_state != state) || bit_end) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end

            if ((state == START) && (next_state == DATA)) begin
                bit_idx <= '0;
            end else if (bit_sample) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end

            // LSB arrives first: insert at the top and shift right.
            if (bit_sample) begin
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            end

            if (stop_sample && rx_s) begin
                // A new byte wins over a same-cycle acceptance; it is only an
                // overrun when the pending byte was never taken.
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
                overrun  <= rx_valid & ~rx_ready;
            end else begin
                if (rx_valid && rx_ready) begin
                    rx_valid <= 1'b0;
                end
                if (stop_sample) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

    localparam int BIT_CLKS = 100_000 / 9600;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    byte unsigned got_q[$];
    byte unsigned exp_q[$];
    int  fe_cnt, ov_cnt, fe_long, ov_long, valid_cycles, busy_rises;
    logic fe_prev = 1'b0, ov_prev = 1'b0, busy_prev = 1'b0;
    int  exp_fe;

    uart_receiver dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Event recorder: accepted bytes and pulse statistics, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (rx_valid) valid_cycles++;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && fe_prev) fe_long++;
        if (overrun && ov_prev) ov_long++;
        if (busy && !busy_prev) busy_rises++;
        fe_prev   = frame_err;
        ov_prev   = overrun;
        busy_prev = busy;
    end

    task automatic clear_counts();
        got_q.delete();
        fe_cnt = 0; ov_cnt = 0; fe_long = 0; ov_long = 0;
        valid_cycles = 0; busy_rises = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame; the line is left high afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; rx_ready = 1'b1;
        clear_counts();
        idle(3);
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        check("reset overrun", overrun, 1'b0);
        check("reset busy", busy, 1'b0);
        rst = 1'b0;
        idle(5);

        // Plain frame, consumer always ready.
        clear_counts();
        send_frame(8'hA5, 1'b1);
        idle(5);
        check("a5 count", got_q.size(), 1);
        if (got_q.size() > 0) check("a5 data", got_q[0], 8'hA5);
        check("a5 valid one cycle", valid_cycles, 1);
        check("a5 no frame_err", fe_cnt, 0);
        check("a5 busy rises", busy_rises, 1);
        check("a5 busy idle", busy, 1'b0);
        check("a5 data held", rx_data, 8'hA5);

        // Bad stop bit.
        clear_counts();
        send_frame(8'h3C, 1'b0);
        idle(5);
        check("3c frame_err pulses", fe_cnt, 1);
        check("3c frame_err width", fe_long, 0);
        check("3c no valid", valid_cycles, 0);
        check("3c data kept", rx_data, 8'hA5);

        // Short low glitch in IDLE.
        clear_counts();
        @(posedge clk); #1;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(15);
        check("glitch start entered", busy_rises, 1);
        check("glitch back idle", busy, 1'b0);
        check("glitch no valid", valid_cycles, 0);
        check("glitch no frame_err", fe_cnt, 0);

        // Overrun: two bytes with no consumer.
        clear_counts();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        check("ovr first valid", rx_valid, 1'b1);
        check("ovr first data", rx_data, 8'h11);
        send_frame(8'h22, 1'b1);
        idle(3);
        check("ovr second data", rx_data, 8'h22);
        check("ovr valid held", rx_valid, 1'b1);
        check("ovr pulse count", ov_cnt, 1);
        check("ovr pulse width", ov_long, 0);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        check("ovr accepted count", got_q.size(), 1);
        if (got_q.size() > 0) check("ovr accepted data", got_q[0], 8'h22);
        check("ovr valid cleared", rx_valid, 1'b0);

        // Acceptance in the very cycle the second byte completes: the
        // mid-stop sample lands 97 clocks after the start edge is driven.
        clear_counts();
        send_frame(8'h11, 1'b1);
        idle(2);
        fork
            send_frame(8'h22, 1'b1);
            begin
                @(posedge clk);
                repeat (97) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        idle(3);
        check("same cyc accepted", got_q.size(), 1);
        if (got_q.size() > 0) check("same cyc old byte", got_q[0], 8'h11);
        check("same cyc no overrun", ov_cnt, 0);
        check("same cyc valid", rx_valid, 1'b1);
        check("same cyc data", rx_data, 8'h22);
        rx_ready = 1'b1;
        idle(2);

        // Reset during data bit 4 of 0xFF.
        fork
            send_frame(8'hFF, 1'b1);
            begin
                @(posedge clk);
                repeat (54) @(posedge clk);
                #1;
                check("mid busy before rst", busy, 1'b1);
                idle(1);
                rst = 1'b1;
                idle(1);
                check("mid rst rx_data", rx_data, 8'h00);
                check("mid rst rx_valid", rx_valid, 1'b0);
                check("mid rst frame_err", frame_err, 1'b0);
                check("mid rst overrun", overrun, 1'b0);
                check("mid rst busy", busy, 1'b0);
                idle(2);
                rst = 1'b0;
            end
        join
        idle(5);
        clear_counts();
        send_frame(8'h81, 1'b1);
        idle(5);
        check("post rst count", got_q.size(), 1);
        if (got_q.size() > 0) check("post rst data", got_q[0], 8'h81);
        check("post rst no frame_err", fe_cnt, 0);
        check("post rst no overrun", ov_cnt, 0);

        // Reset released while the line is low: no frame may start.
        rx = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        clear_counts();
        idle(30);
        check("low rst no start", busy_rises, 0);
        rx = 1'b1;
        idle(5);
        send_frame(8'h5A, 1'b1);
        idle(5);
        check("low rst then frame", got_q.size(), 1);
        if (got_q.size() > 0) check("low rst frame data", got_q[0], 8'h5A);

        // Random frames against a queue model.
        clear_counts();
        exp_q.delete();
        exp_fe = 0;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] b;
            logic       sb;
            b  = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 3) != 0);
            if (sb) exp_q.push_back(b);
            else exp_fe++;
            send_frame(b, sb);
            idle($urandom_range(2, 20));
        end
        idle(5);
        check("rand count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("rand byte %0d", i), got_q[i], exp_q[i]);
        end
        check("rand frame_err", fe_cnt, exp_fe);
        check("rand overrun", ov_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
